// File: rtl/mnist_pkg.sv
// Shared types and sizing for the MNIST 784-32-10 MLP accelerator control path.
// State encoding is fixed at 4 bits; codes above DONE are illegal.
package mnist_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        INIT     = 4'd1,
        LOAD_IMG = 4'd2,
        L1_COMP  = 4'd3,
        L1_RELU  = 4'd4,
        L2_COMP  = 4'd5,
        ARGMAX   = 4'd6,
        DONE     = 4'd7
    } state_t;

    localparam int MNIST_N_IN     = 784;
    localparam int MNIST_N_HID    = 32;
    localparam int MNIST_N_OUT    = 10;
    localparam int MNIST_MAC_LAT  = 1;
    localparam int MNIST_RELU_CYC = 2;
    localparam int CNT_W          = 10;

    localparam logic [1:0] LSEL_NONE = 2'd0;
    localparam logic [1:0] LSEL_L1   = 2'd1;
    localparam logic [1:0] LSEL_L2   = 2'd2;

endpackage

// File: rtl/ctrl_phase_cnt.sv
// Per-state cycle counter: clears on state change, otherwise counts up and saturates.
// Latency: one clock from clr to zero; no backpressure.
module ctrl_phase_cnt
    import mnist_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != {W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_fsm.sv
// Inference sequencer for the MNIST MLP: clear, load, L1 sweep, ReLU, L2 sweep, argmax, done.
// All outputs decode from state/cycle_cnt/done; define CTRL_FSM_ASSERT_EN for simulation checks.
module ctrl_fsm
    import mnist_pkg::*;
#(
    parameter int N_IN     = MNIST_N_IN,
    parameter int N_HID    = MNIST_N_HID,
    parameter int MAC_LAT  = MNIST_MAC_LAT,
    parameter int RELU_CYC = MNIST_RELU_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic [1:0]  layer_sel,
    output logic [9:0]  row_idx,
    output logic        mac_en_l1,
    output logic        mac_clr_l1,
    output logic        mac_en_l2,
    output logic        mac_clr_l2,
    output logic        load_img,
    output logic        comp_l1,
    output logic        apply_relu,
    output logic        comp_l2,
    output logic        find_max,
    output logic [9:0]  cycle_cnt
);

    localparam logic [9:0] L1_LAST   = 10'(N_IN + MAC_LAT - 1);
    localparam logic [9:0] L2_LAST   = 10'(N_HID + MAC_LAT - 1);
    localparam logic [9:0] RELU_LAST = 10'(RELU_CYC - 1);
    localparam logic [9:0] MAC_FIRST = 10'(MAC_LAT);

    state_t state;
    logic   done_q;
    logic   leave;

    // Exit condition of the current state; also restarts the phase counter.
    always_comb begin
        leave = 1'b1;
        case (state)
            IDLE:    leave = start;
            L1_COMP: leave = (cycle_cnt == L1_LAST);
            L1_RELU: leave = (cycle_cnt == RELU_LAST);
            L2_COMP: leave = (cycle_cnt == L2_LAST);
            default: leave = 1'b1;
        endcase
    end

    ctrl_phase_cnt #(.W(10)) u_phase_cnt (
        .clk (clk),
        .rst (rst),
        .clr (leave),
        .cnt (cycle_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= INIT;
                        done_q <= 1'b0;
                    end
                end
                INIT:     state <= LOAD_IMG;
                LOAD_IMG: state <= L1_COMP;
                L1_COMP:  if (leave) state <= L1_RELU;
                L1_RELU:  if (leave) state <= L2_COMP;
                L2_COMP:  if (leave) state <= ARGMAX;
                ARGMAX: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign done       = done_q;
    assign busy       = (state == INIT) || (state == LOAD_IMG) || (state == L1_COMP) ||
                        (state == L1_RELU) || (state == L2_COMP) || (state == ARGMAX);
    assign load_img   = (state == LOAD_IMG);
    assign comp_l1    = (state == L1_COMP);
    assign apply_relu = (state == L1_RELU);
    assign comp_l2    = (state == L2_COMP);
    assign find_max   = (state == ARGMAX);
    assign mac_clr_l1 = (state == INIT);
    assign mac_clr_l2 = (state == INIT);

    // Enable trails row_idx by MAC_LAT so it lines up with returning weight data.
    assign mac_en_l1  = comp_l1 && (cycle_cnt >= MAC_FIRST) && (cycle_cnt <= L1_LAST);
    assign mac_en_l2  = comp_l2 && (cycle_cnt >= MAC_FIRST) && (cycle_cnt <= L2_LAST);
    assign row_idx    = (comp_l1 || comp_l2) ? cycle_cnt : 10'd0;

    always_comb begin
        layer_sel = LSEL_NONE;
        if (load_img || comp_l1 || apply_relu) begin
            layer_sel = LSEL_L1;
        end else if (comp_l2 || find_max) begin
            layer_sel = LSEL_L2;
        end
    end

`ifdef CTRL_FSM_ASSERT_EN
    logic [3:0] prev_state;

    always @(posedge clk or posedge rst) begin
        if (rst) prev_state <= 4'd0;
        else     prev_state <= state;
    end

    // Checked mid-cycle so prev_state and state are both settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (4'(state) > 4'd7)
                $error("ctrl_fsm: illegal state code %0d", state);
            if ($countones({load_img, comp_l1, apply_relu, comp_l2, find_max}) > 1)
                $error("ctrl_fsm: more than one phase flag active");
            if (mac_en_l1 && !comp_l1)
                $error("ctrl_fsm: mac_en_l1 outside L1_COMP");
            if ((state == INIT) && (prev_state != 4'(IDLE)))
                $error("ctrl_fsm: start accepted while busy");
        end
    end
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed self-checking bench for ctrl_fsm: reset, phase timing, pulse counts, done handling.
module tb_ctrl_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       done, busy;
    logic [1:0] layer_sel;
    logic [9:0] row_idx, cycle_cnt;
    logic       mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2;
    logic       load_img, comp_l1, apply_relu, comp_l2, find_max;
    logic [3:0] st;

    int ncmp = 0;
    int nerr = 0;
    int lat, n_l1, n_l2, n_relu, n_max, row_err;

    ctrl_fsm dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .layer_sel(layer_sel), .row_idx(row_idx),
        .mac_en_l1(mac_en_l1), .mac_clr_l1(mac_clr_l1),
        .mac_en_l2(mac_en_l2), .mac_clr_l2(mac_clr_l2),
        .load_img(load_img), .comp_l1(comp_l1), .apply_relu(apply_relu),
        .comp_l2(comp_l2), .find_max(find_max), .cycle_cnt(cycle_cnt)
    );

    assign st = dut.state;

    always #5 clk = ~clk;

    function automatic logic [21:0] strobes();
        return {busy, done, layer_sel, row_idx, mac_en_l1, mac_clr_l1, mac_en_l2,
                mac_clr_l2, load_img, comp_l1, apply_relu, comp_l2, find_max};
    endfunction

    // Leaves the DUT having just sampled start (INIT visible).
    task automatic do_start(input bit hold);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = hold;
    endtask

    // Steps until done or a cycle budget expires, collecting pulse statistics.
    task automatic measure(input bit hold, input bit pulse_l2);
        int k;
        k = 0; n_l1 = 0; n_l2 = 0; n_relu = 0; n_max = 0; row_err = 0;
        while (k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (!hold) start = pulse_l2 && comp_l2 && (cycle_cnt >= 10'd5) && (cycle_cnt <= 10'd7);
            if (mac_en_l1) begin n_l1++; if (row_idx != 10'(n_l1)) row_err++; end
            if (mac_en_l2) begin n_l2++; if (row_idx != 10'(n_l2)) row_err++; end
            if (apply_relu) n_relu++;
            if (find_max) n_max++;
            if (done) break;
        end
        lat = k;
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ncmp++;
            if (st !== 4'd0 || strobes() !== 22'd0) begin
                nerr++;
                $display("FAIL reset_idle cyc %0d: state=%0d strobes=%h, want state=0 strobes=0", i, st, strobes());
            end
        end
    endtask

    task automatic test_start_pulse();
        do_start(0);
        ncmp++;
        if (st !== 4'd1 || mac_clr_l1 !== 1'b1 || mac_clr_l2 !== 1'b1 || busy !== 1'b1 || layer_sel !== 2'd0) begin
            nerr++;
            $display("FAIL init_state: state=%0d clr=%b%b busy=%b lsel=%0d, want 1 11 1 0",
                     st, mac_clr_l1, mac_clr_l2, busy, layer_sel);
        end
        @(posedge clk); #1;
        ncmp++;
        if (st !== 4'd2 || load_img !== 1'b1 || layer_sel !== 2'd1 || mac_clr_l1 !== 1'b0) begin
            nerr++;
            $display("FAIL load_img_state: state=%0d load=%b lsel=%0d clr=%b, want 2 1 1 0",
                     st, load_img, layer_sel, mac_clr_l1);
        end
        measure(0, 0);
        ncmp++;
        if (done !== 1'b1) begin
            nerr++;
            $display("FAIL start_pulse_done: done=%b want 1 (timeout)", done);
        end
    endtask

    task automatic test_full_run();
        do_start(0);
        measure(0, 0);
        ncmp++;
        if (lat != 823) begin nerr++; $display("FAIL full_latency: got %0d want 823", lat); end
        ncmp++;
        if (n_l1 != 784) begin nerr++; $display("FAIL l1_pulses: got %0d want 784", n_l1); end
        ncmp++;
        if (n_relu != 2) begin nerr++; $display("FAIL relu_cycles: got %0d want 2", n_relu); end
        ncmp++;
        if (n_l2 != 32) begin nerr++; $display("FAIL l2_pulses: got %0d want 32", n_l2); end
        ncmp++;
        if (n_max != 1) begin nerr++; $display("FAIL argmax_cycles: got %0d want 1", n_max); end
        ncmp++;
        if (row_err != 0) begin nerr++; $display("FAIL row_idx_seq: got %0d bad rows want 0", row_err); end
        ncmp++;
        if (st !== 4'd7 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL done_state: state=%0d busy=%b want 7 0", st, busy);
        end
    endtask

    task automatic test_done_sticky();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ncmp++;
            if (st !== 4'd0 || done !== 1'b1 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL done_sticky cyc %0d: state=%0d done=%b busy=%b want 0 1 0", i, st, done, busy);
            end
        end
        do_start(0);
        ncmp++;
        if (st !== 4'd1 || done !== 1'b0) begin
            nerr++;
            $display("FAIL done_clear: state=%0d done=%b want 1 0", st, done);
        end
        measure(0, 0);
        ncmp++;
        if (lat != 823) begin nerr++; $display("FAIL rerun_latency: got %0d want 823", lat); end
    endtask

    task automatic test_back_to_back();
        do_start(1);
        measure(1, 0);
        ncmp++;
        if (lat != 823) begin nerr++; $display("FAIL b2b_first_latency: got %0d want 823", lat); end
        @(posedge clk); #1;
        ncmp++;
        if (st !== 4'd0 || done !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_idle: state=%0d done=%b want 0 1", st, done);
        end
        @(posedge clk); #1;
        ncmp++;
        if (st !== 4'd1 || done !== 1'b0 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_restart: state=%0d done=%b busy=%b want 1 0 1", st, done, busy);
        end
        measure(1, 0);
        start = 1'b0;
        ncmp++;
        if (lat != 823 || n_l1 != 784) begin
            nerr++;
            $display("FAIL b2b_second: lat=%0d l1=%0d want 823 784", lat, n_l1);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        do_start(0);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (comp_l1 && cycle_cnt == 10'd400) begin found = 1'b1; break; end
        end
        ncmp++;
        if (!found) begin nerr++; $display("FAIL reach_l1_400: got 0 want 1 (timeout)"); end
        #2 rst = 1'b1;
        #1;
        ncmp++;
        if (st !== 4'd0 || strobes() !== 22'd0 || cycle_cnt !== 10'd0) begin
            nerr++;
            $display("FAIL async_reset: state=%0d strobes=%h cnt=%0d want 0 0 0", st, strobes(), cycle_cnt);
        end
        @(posedge clk); #1 rst = 1'b0;
        do_start(0);
        measure(0, 0);
        ncmp++;
        if (lat != 823 || n_l1 != 784 || n_l2 != 32) begin
            nerr++;
            $display("FAIL post_reset_run: lat=%0d l1=%0d l2=%0d want 823 784 32", lat, n_l1, n_l2);
        end
    endtask

    task automatic test_start_ignored();
        do_start(0);
        measure(0, 1);
        ncmp++;
        if (lat != 823 || n_l2 != 32 || n_max != 1) begin
            nerr++;
            $display("FAIL start_in_l2: lat=%0d l2=%0d max=%0d want 823 32 1", lat, n_l2, n_max);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        ncmp++;
        if (st !== 4'd0 || done !== 1'b1) begin
            nerr++;
            $display("FAIL no_extra_run: state=%0d done=%b want 0 1", st, done);
        end
    endtask

    initial begin
        test_reset();
        test_start_pulse();
        test_full_run();
        test_done_sticky();
        test_back_to_back();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
